// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle for the branch predictor.
// The master drives fetch PC and branch resolution; the slave returns the prediction and redirect.
interface branch_predictor_if;
  logic [31:0] PC_IF;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        BranchE;
  logic        StallE;
  logic [31:0] PC_EX;
  logic        BranchJump;
  logic [31:0] BrTarget;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MissCount;

  modport master (
    output PC_IF, BranchE, StallE, PC_EX, BranchJump, BrTarget, PredTakenE, PredTargetE,
    input  PredTaken, PredTarget, Mispredict, RedirectPC, BranchCount, MissCount
  );

  modport slave (
    input  PC_IF, BranchE, StallE, PC_EX, BranchJump, BrTarget, PredTakenE, PredTargetE,
    output PredTaken, PredTarget, Mispredict, RedirectPC, BranchCount, MissCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Lookup is combinational on registered state; training happens at the edge after an unstalled EX branch.
module branch_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES = 2**IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         cnt_q    [ENTRIES];
  logic [1:0]         cnt_d    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [31:0]        branch_cnt_q, branch_cnt_d;
  logic [31:0]        miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit, pred_taken, mispredict, train_en;
  logic             unused_pc_low;

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign if_idx = bp.PC_IF[IDX_W+1:2];
  assign if_tag = bp.PC_IF[31:IDX_W+2];
  assign ex_idx = bp.PC_EX[IDX_W+1:2];
  assign ex_tag = bp.PC_EX[31:IDX_W+2];
  // Byte offset within the instruction word never participates in lookup.
  assign unused_pc_low = ^{bp.PC_IF[1:0], bp.PC_EX[1:0]};

  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign pred_taken = if_hit && cnt_q[if_idx][1];

  assign bp.PredTaken  = pred_taken;
  assign bp.PredTarget = pred_taken ? target_q[if_idx] : bp.PC_IF + 32'd4;

  assign mispredict = rst_n && bp.BranchE &&
                      ((bp.PredTakenE != bp.BranchJump) ||
                       (bp.BranchJump && (bp.PredTargetE != bp.BrTarget)));
  assign bp.Mispredict  = mispredict;
  assign bp.RedirectPC  = bp.BranchJump ? bp.BrTarget : bp.PC_EX + 32'd4;
  assign bp.BranchCount = branch_cnt_q;
  assign bp.MissCount   = miss_cnt_q;

  assign train_en = bp.BranchE && !bp.StallE;

  always_comb begin
    valid_d      = valid_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    target_d     = target_q;
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (train_en) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict) miss_cnt_d = miss_cnt_q + 32'd1;
      if (ex_hit) begin
        cnt_d[ex_idx] = sat_step(cnt_q[ex_idx], bp.BranchJump);
        if (bp.BranchJump) target_d[ex_idx] = bp.BrTarget;
      end else if (bp.BranchJump) begin
        // Taken miss evicts whatever lives at this index.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = bp.BrTarget;
        cnt_d[ex_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else begin
      valid_q      <= valid_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Tag and target payload are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      tag_q[i]    <= tag_d[i];
      target_q[i] <= target_d[i];
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expected responses from a PC-keyed
// reference model; a negedge monitor pops and compares every cycle.
module tb_branch_predictor;
  localparam int IDX_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bp();

  branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bp   (bp)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        misp;
    logic [31:0] redir;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: one remembered branch PC per index slot, its last taken target and a 0..3 strength.
  logic [31:0] m_pc  [int];
  logic [31:0] m_tgt [int];
  int          m_str [int];
  logic [31:0] m_bc = 0;
  logic [31:0] m_mc = 0;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % (1 << IDX_W));
  endfunction

  function automatic logic knows(input logic [31:0] pc);
    int s = slot(pc);
    return m_pc.exists(s) && ((m_pc[s] >> 2) == (pc >> 2));
  endfunction

  task automatic predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    t   = knows(pc) && (m_str[slot(pc)] >= 2);
    tgt = t ? m_tgt[slot(pc)] : pc + 32'd4;
  endtask

  task automatic model_reset();
    m_pc.delete(); m_tgt.delete(); m_str.delete();
    m_bc = 0; m_mc = 0;
  endtask

  task automatic step(input logic rst_hold, input logic [31:0] pc_if, input logic br,
                      input logic stall, input logic [31:0] pc_ex, input logic bj,
                      input logic [31:0] brt, input logic pte, input logic [31:0] ptge);
    exp_t e;
    logic misp;
    int   s;
    @(posedge clk);
    #1;
    rst_n          = !rst_hold;
    bp.PC_IF       = pc_if;
    bp.BranchE     = br;
    bp.StallE      = stall;
    bp.PC_EX       = pc_ex;
    bp.BranchJump  = bj;
    bp.BrTarget    = brt;
    bp.PredTakenE  = pte;
    bp.PredTargetE = ptge;
    if (rst_hold) model_reset();
    misp = !rst_hold && br && ((pte != bj) || (bj && ptge != brt));
    predict(pc_if, e.pt, e.ptgt);
    e.misp  = misp;
    e.redir = bj ? brt : pc_ex + 32'd4;
    e.bc    = m_bc;
    e.mc    = m_mc;
    sb.push_back(e);
    if (!rst_hold && br && !stall) begin
      s = slot(pc_ex);
      m_bc = m_bc + 1;
      if (misp) m_mc = m_mc + 1;
      if (knows(pc_ex)) begin
        m_str[s] = bj ? ((m_str[s] < 3) ? m_str[s] + 1 : 3) : ((m_str[s] > 0) ? m_str[s] - 1 : 0);
        if (bj) m_tgt[s] = brt;
      end else if (bj) begin
        m_pc[s] = pc_ex; m_tgt[s] = brt; m_str[s] = 2;
      end
    end
  endtask

  // Resolve a branch with PredTakenE/PredTargetE taken from what fetch would have predicted.
  task automatic dstep(input logic [31:0] pc_if, input logic br, input logic stall,
                       input logic [31:0] pc_ex, input logic bj, input logic [31:0] brt);
    logic t; logic [31:0] tg;
    predict(pc_ex, t, tg);
    step(1'b0, pc_if, br, stall, pc_ex, bj, brt, t, tg);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("PredTaken",   {31'd0, bp.PredTaken},  {31'd0, e.pt});
      chk("PredTarget",  bp.PredTarget,          e.ptgt);
      chk("Mispredict",  {31'd0, bp.Mispredict}, {31'd0, e.misp});
      chk("RedirectPC",  bp.RedirectPC,          e.redir);
      chk("BranchCount", bp.BranchCount,         e.bc);
      chk("MissCount",   bp.MissCount,           e.mc);
    end
  end

  initial begin
    logic [31:0] pc_if, pc_ex, brt, tg;
    logic        bj, t;
    bp.PC_IF = 0; bp.BranchE = 0; bp.StallE = 0; bp.PC_EX = 0;
    bp.BranchJump = 0; bp.BrTarget = 0; bp.PredTakenE = 0; bp.PredTargetE = 0;

    // Reset, with a branch presented to confirm Mispredict is held low.
    step(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // First taken resolution allocates; same-cycle lookup of the same PC sees old state.
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Saturation up then back down across the taken/not-taken threshold.
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80);
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h80);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Aliasing on index 0.
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
    dstep(32'h200, 1'b1, 1'b0, 32'h200, 1'b1, 32'h300);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    dstep(32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Target change on a predicted-taken hit.
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80);
    dstep(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h90);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Stalled branch held for three cycles trains once.
    for (int i = 0; i < 3; i++) dstep(32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 32'h400);
    dstep(32'h40, 1'b1, 1'b0, 32'h40, 1'b1, 32'h400);
    dstep(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Mid-operation reset drops every entry.
    step(1'b1, 32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    dstep(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    dstep(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Random traffic over a small PC pool so hits, aliases and evictions are frequent.
    for (int n = 0; n < 400; n++) begin
      pc_if = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      pc_ex = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      bj    = $urandom_range(0, 1);
      brt   = $urandom_range(0, 3) == 0 ? $urandom : (32'h1000 + ($urandom_range(0, 3) << 4));
      predict(pc_ex, t, tg);
      if ($urandom_range(0, 3) == 0) begin
        t  = $urandom_range(0, 1);
        tg = $urandom;
      end
      step($urandom_range(0, 60) == 0, pc_if, $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, pc_ex, bj, brt, t, tg);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Predicts direction and target for the instruction at the IF-stage PC.
- Trained by the execute-stage branch resolution (actual taken/not-taken and actual target).
- Flags mispredictions so the hazard unit can flush IF/ID and redirect the PC.

Parameters:
- IDX_W, 6, index bits; ENTRIES = 2**IDX_W.
- CNT_INIT, 2'b01, counter value loaded at reset (weakly not-taken).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- PC_IF  input  32  PC of the instruction being fetched.
- PredTaken  output  1  prediction for PC_IF: taken.
- PredTarget  output  32  predicted target for PC_IF; equals PC_IF+4 when PredTaken=0.
- BranchE  input  1  EX holds a conditional branch (branch type not NOBRANCH).
- StallE  input  1  EX stage stalled; suppresses training and statistics.
- PC_EX  input  32  PC of the EX-stage branch.
- BranchJump  input  1  actual outcome from branch resolution.
- BrTarget  input  32  actual taken target (PC_EX + immediate).
- PredTakenE  input  1  PredTaken piped along with the EX instruction.
- PredTargetE  input  32  PredTarget piped along with the EX instruction.
- Mispredict  output  1  EX branch was mispredicted; redirect required.
- RedirectPC  output  32  correct next PC: BrTarget if BranchJump, else PC_EX+4.
- BranchCount  output  32  resolved-branch counter.
- MissCount  output  32  misprediction counter.

Behaviour:
- Entry fields: valid, tag = PC[31:IDX_W+2], target[31:0], cnt[1:0]. Index = PC[IDX_W+1:2]; PC[1:0] is ignored.
- Reset (rst_n=0, asynchronous):
  - all valid=0, all cnt=CNT_INIT;
  - BranchCount=0, MissCount=0.
  - Combinational outputs during reset: PredTaken=0, PredTarget=PC_IF+4, Mispredict=0.
- Lookup (combinational, zero latency on registered state):
  - hit = valid[idx] && tag match;
  - PredTaken = hit && cnt[1];
  - PredTarget = PredTaken ? target : PC_IF+4.
- Mispredict (combinational):
  - Mispredict = BranchE && ((PredTakenE != BranchJump) || (BranchJump && PredTargetE != BrTarget));
  - forced 0 when BranchE=0.
- Training: on posedge clk, only when BranchE && !StallE.
  - Hit at PC_EX index:
    - cnt increments if BranchJump, else decrements, saturating at 2'b11 and 2'b00;
    - if BranchJump, target <= BrTarget.
  - Miss and BranchJump=1: allocate (replace any occupant):
    - valid=1, tag=PC_EX tag, target=BrTarget, cnt=2'b10.
  - Miss and BranchJump=0: no state change.
- Statistics: on the same enable condition,
  - BranchCount += 1;
  - MissCount += 1 if Mispredict.
  - Both wrap modulo 2^32.
- Same-cycle lookup and training on the same index: the lookup returns the pre-update contents. The write takes effect at the clock edge and is visible to PC_IF on the next cycle.
- Aliasing: a different PC that maps to the same index is a miss (tag mismatch) and never uses the other PC's counter.
- StallE=1 with BranchE=1: Mispredict is still evaluated combinationally, but no state or counter changes. Each branch trains exactly once, in its unstalled cycle.
- Reset asserted mid-operation: all entries are invalidated immediately; the next lookup predicts not-taken.
- Storage: register array, so that reset is asynchronous; no RAM macro.

Test Plan:
1. Reset, then PC_IF=0x100 -> PredTaken=0, PredTarget=0x104, BranchCount=0, MissCount=0.
2. Resolve PC_EX=0x100, BranchJump=1, BrTarget=0x80, PredTakenE=0 -> Mispredict=1, RedirectPC=0x80. Next cycle, PC_IF=0x100 gives PredTaken=1, PredTarget=0x80; MissCount=1, BranchCount=1.
3. Saturation: after allocation (cnt=10), resolve 0x100 taken twice, then not-taken once -> still predicted taken. A second not-taken gives cnt=01 -> PredTaken=0.
4. Aliasing, with IDX_W=6: allocate 0x100 (target 0x80), then resolve 0x200 taken to 0x300 -> lookup 0x100 misses (PredTaken=0) and lookup 0x200 predicts 0x300.
5. Target change: hit at 0x100 predicted 0x80, actual taken to 0x90 -> Mispredict=1. Next lookup yields PredTarget=0x90.
6. StallE=1 with BranchE=1 for 3 cycles, then StallE=0 -> counters increment once only. Separately, a training write and a lookup of the same PC in the same cycle -> the lookup shows the old prediction; the following cycle shows the new one.
